// File: rtl/mash_pkg.sv
// Shared types, LFSR constants and the output clamp for the MASH 1-1 channel array.
// Clamp works at SAT_W bits so any DAC_BW up to SAT_W-3 can reuse it.
package mash_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int SAT_W = 16;

    function automatic logic [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] y,
        input int unsigned             bw
    );
        logic signed [SAT_W-1:0] max_v;
        max_v = signed'((SAT_W'(1) << bw) - SAT_W'(1));
        if (y < 0) begin
            saturate = '0;
        end else if (y > max_v) begin
            saturate = max_v;
        end else begin
            saturate = y;
        end
    endfunction

endpackage

// File: rtl/mash11_slice.sv
// One channel step of a MASH 1-1 modulator: two cascaded accumulators plus
// the first-difference of the second carry, clamped to the DAC code range.
module mash11_slice
    import mash_pkg::*;
#(
    parameter int DAC_BW = 5,
    parameter int FRAC_W = 11
) (
    input  logic [DAC_BW-1:0] int_val,
    input  logic [FRAC_W-1:0] frac_val,
    input  logic              cin,
    input  logic [FRAC_W-1:0] acc1,
    input  logic [FRAC_W-1:0] acc2,
    input  logic              c2_d,
    output logic [FRAC_W-1:0] acc1_nxt,
    output logic [FRAC_W-1:0] acc2_nxt,
    output logic              c2_nxt,
    output logic [DAC_BW-1:0] y_sat
);

    localparam int YW = DAC_BW + 2;

    logic                 c1;
    logic signed [YW-1:0] y;

    always_comb begin
        {c1, acc1_nxt}     = {1'b0, acc1} + {1'b0, frac_val} + {{FRAC_W{1'b0}}, cin};
        {c2_nxt, acc2_nxt} = {1'b0, acc2} + {1'b0, acc1_nxt};
        // Range is -1 .. 2^DAC_BW+1, so two extra bits keep it exact before clamping
        y     = signed'(YW'(int_val)) + signed'(YW'(c1)) + signed'(YW'(c2_nxt))
              - signed'(YW'(c2_d));
        y_sat = DAC_BW'(saturate({{(SAT_W-YW){y[YW-1]}}, y}, DAC_BW));
    end

endmodule

// File: rtl/axis_mash11_array.sv
// NUM_CH-channel MASH 1-1 noise shaper sharing one slice; output valid NUM_CH cycles after accept.
// Input ready only in IDLE; output held until downstream ready. MASH_DITHER_EN adds an LFSR carry-in.
module axis_mash11_array
    import mash_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DAC_BW = 5,
    parameter int FRAC_W = 11
) (
    input  logic                             aclk,
    input  logic                             arst_n,
    input  logic [NUM_CH*(DAC_BW+FRAC_W)-1:0] s_axis_data_tdata,
    input  logic                             s_axis_data_tvalid,
    output logic                             s_axis_data_tready,
    output logic [NUM_CH*DAC_BW-1:0]          m_axis_data_tdata,
    output logic                             m_axis_data_tvalid,
    input  logic                             m_axis_data_tready,
    input  logic                             clr
);

    localparam int WIDTH = DAC_BW + FRAC_W;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OUT_W = NUM_CH * DAC_BW;

    state_t                    state_q, state_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [NUM_CH*WIDTH-1:0]   din_q, din_d;
    logic [OUT_W-1:0]          tdata_q, tdata_d;
    logic                      tvalid_q, tvalid_d;
    logic                      tready_q, tready_d;
    logic                      pend_q, pend_d;
    logic [FRAC_W-1:0]         acc1_q [NUM_CH];
    logic [FRAC_W-1:0]         acc1_d [NUM_CH];
    logic [FRAC_W-1:0]         acc2_q [NUM_CH];
    logic [FRAC_W-1:0]         acc2_d [NUM_CH];
    logic                      c2d_q  [NUM_CH];
    logic                      c2d_d  [NUM_CH];
    logic                      do_clear;
    logic                      cin;

    logic [WIDTH-1:0]          chan_word;
    logic [FRAC_W-1:0]         acc1_nxt, acc2_nxt;
    logic                      c2_nxt;
    logic [DAC_BW-1:0]         y_sat;

    assign chan_word = din_q[ch_q*WIDTH +: WIDTH];

    mash11_slice #(
        .DAC_BW (DAC_BW),
        .FRAC_W (FRAC_W)
    ) u_slice (
        .int_val  (chan_word[WIDTH-1 -: DAC_BW]),
        .frac_val (chan_word[FRAC_W-1:0]),
        .cin      (cin),
        .acc1     (acc1_q[ch_q]),
        .acc2     (acc2_q[ch_q]),
        .c2_d     (c2d_q[ch_q]),
        .acc1_nxt (acc1_nxt),
        .acc2_nxt (acc2_nxt),
        .c2_nxt   (c2_nxt),
        .y_sat    (y_sat)
    );

`ifdef MASH_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign cin = lfsr_q[0];

    always_comb begin
        lfsr_d = lfsr_q;
        if (do_clear) begin
            lfsr_d = LFSR_SEED;
        end else if (state_q == CALC) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign cin = 1'b0;
`endif

    // A clear request blocks acceptance in the same cycle it zeroes the state
    assign s_axis_data_tready = tready_q & ~clr;
    assign m_axis_data_tdata  = tdata_q;
    assign m_axis_data_tvalid = tvalid_q;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        din_d    = din_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tready_d = tready_q;
        pend_d   = pend_q;
        acc1_d   = acc1_q;
        acc2_d   = acc2_q;
        c2d_d    = c2d_q;
        do_clear = 1'b0;

        case (state_q)
            IDLE: begin
                tready_d = 1'b1;
                if (clr) begin
                    do_clear = 1'b1;
                end else if (s_axis_data_tvalid && tready_q) begin
                    din_d    = s_axis_data_tdata;
                    ch_d     = '0;
                    tready_d = 1'b0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc1_d[ch_q] = acc1_nxt;
                acc2_d[ch_q] = acc2_nxt;
                c2d_d[ch_q]  = c2_nxt;
                tdata_d[ch_q*DAC_BW +: DAC_BW] = y_sat;
                pend_d = pend_q | clr;
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    ch_d     = '0;
                    tvalid_d = 1'b1;
                    state_d  = OUT;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            OUT: begin
                pend_d = pend_q | clr;
                if (m_axis_data_tready) begin
                    tvalid_d = 1'b0;
                    tready_d = 1'b1;
                    do_clear = pend_q | clr;
                    pend_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc1_d[i] = '0;
                acc2_d[i] = '0;
                c2d_d[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            din_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tready_q <= 1'b0;
            pend_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc1_q[i] <= '0;
                acc2_q[i] <= '0;
                c2d_q[i]  <= 1'b0;
            end
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            din_q    <= din_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tready_q <= tready_d;
            pend_q   <= pend_d;
            acc1_q   <= acc1_d;
            acc2_q   <= acc2_d;
            c2d_q    <= c2d_d;
        end
    end

endmodule

// File: doc/axis_mash11_array.md
AXIS_MASH11_ARRAY -- requirements
Module: axis_mash11_array

Interface
REQ-001 Parameters SHALL be as follows, one per line (name, default, meaning):
  NUM_CH, 4, channel count, 1..16.
  DAC_BW, 5, integer/output bits per channel.
  FRAC_W, 11, fractional bits per channel, shaped by MASH 1-1.
  WIDTH = DAC_BW+FRAC_W, 16, input word per channel (localparam).
REQ-002 Ports SHALL be as follows, one per line (name  direction  width  meaning):
  aclk  in  1  single clock, all logic on rising edge.
  arst_n  in  1  asynchronous active-low reset.
  s_axis_data_tdata  in  NUM_CH*WIDTH  channel c at bits [c*WIDTH +: WIDTH], unsigned {int,frac}.
  s_axis_data_tvalid  in  1  input sample valid.
  s_axis_data_tready  out  1  input accepted when high with tvalid.
  m_axis_data_tdata  out  NUM_CH*DAC_BW  channel c at bits [c*DAC_BW +: DAC_BW], unsigned.
  m_axis_data_tvalid  out  1  output sample valid.
  m_axis_data_tready  in  1  downstream ready.
  clr  in  1  synchronous request to zero all modulator state.

Function
REQ-003 One shared MASH 1-1 datapath SHALL be time-multiplexed over NUM_CH channels; per-channel acc1, acc2 (FRAC_W bits each) and c2_d (1 bit) are held in register arrays.
REQ-004 FSM states SHALL be IDLE, CALC, OUT; IDLE->CALC on input handshake; CALC->OUT after channel NUM_CH-1 is processed; OUT->IDLE on output handshake.
REQ-005 s_axis_data_tready SHALL be 1 only in IDLE; input tdata is latched on the handshake edge.
REQ-006 In CALC, channel index ch SHALL start at 0 and increment by 1 per cycle, processing exactly one channel per cycle.
REQ-007 Per channel: {c1,s1} = acc1 + F + cin; {c2,s2} = acc2 + s1; acc1<=s1; acc2<=s2; c2_d<=c2; y = I + c1 + c2 - c2_d_old, computed signed with DAC_BW+2 bits.
REQ-008 y SHALL saturate to [0, 2^DAC_BW-1] before being written to output lane ch.
REQ-009 m_axis_data_tvalid SHALL rise NUM_CH cycles after the input handshake edge; minimum throughput is one sample per NUM_CH+2 cycles.
REQ-010 In OUT, m_axis_data_tdata and m_axis_data_tvalid SHALL hold stable until m_axis_data_tready=1.
REQ-011 clr asserted in IDLE SHALL zero all acc1/acc2/c2_d on that edge; input acceptance SHALL be suppressed that cycle.
REQ-012 clr asserted in CALC or OUT SHALL set a pending flag; the current sample completes unaltered, and the clear is applied on the edge entering IDLE.
REQ-013 Two's-complement wrap of acc1/acc2 at 2^FRAC_W is the intended modulo behaviour and is not an error.

Reset
REQ-014 arst_n low SHALL asynchronously force the following: FSM=IDLE; ch=0; all acc1/acc2/c2_d=0; clr pending=0; m_axis_data_tvalid=0; m_axis_data_tdata=0; s_axis_data_tready=0 while reset is asserted.
REQ-015 s_axis_data_tready SHALL be 1 on the first cycle after arst_n deasserts.

Configuration
REQ-016 With MASH_DITHER_EN defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) SHALL supply cin and advance once per CALC cycle; clr SHALL reseed it.
REQ-017 Without MASH_DITHER_EN, cin SHALL be 0 and no LFSR logic SHALL exist.

Structure
REQ-018 Package mash_pkg SHALL hold: the FSM state enum, the LFSR seed and tap constants, and a saturate function.
REQ-019 Sub-module mash11_slice SHALL implement the combinational REQ-007/008 arithmetic; it is instantiated once.

Verification (NUM_CH=4, DAC_BW=5, FRAC_W=11, MASH_DITHER_EN undefined)
REQ-020 Reset release -> all outputs 0, s_axis_data_tready=1 next cycle; a handshake yields m_axis_data_tvalid exactly 4 cycles later.
REQ-021 All lanes 16'h5000 (I=10, F=0), 32 samples -> every lane outputs 10 on every sample.
REQ-022 All lanes 16'h5400 (I=10, F=0.5) after clr, 16 samples -> first sample outputs 10, values stay in 9..12, and the lane sum is 168.
REQ-023 Lane0 16'hFFFF, lane1 16'h0001, 64 samples -> lane0 stays <=31 and lane1 stays >=0, with no wrap.
REQ-024 m_axis_data_tready=0 for 20 cycles in OUT -> tdata/tvalid stable and s_axis_data_tready=0; ready=1 -> IDLE next cycle.
REQ-025 clr pulsed on the second CALC cycle -> the in-flight sample is unaffected, state is zero after IDLE is re-entered, and the next 16'h5400 sample outputs 10.
